// File: rtl/polyeval_seq_if.sv
// Handshake and bus bundle for polyeval_seq: start/parameters, coefficient
// memory read port, external ALU step port and completion status.
interface polyeval_seq_if #(
    parameter int WID_D = 32,
    parameter int WID_F = 32,
    parameter int CNT_W = 5
);
    logic             start;
    logic [WID_F-1:0] x;
    logic [CNT_W-1:0] deg;
    logic             coef_rd;
    logic [CNT_W-1:0] coef_addr;
    logic [WID_D-1:0] coef_rdata;
    logic [WID_D-1:0] alu_a_left;
    logic [WID_D-1:0] alu_a_right;
    logic [WID_F-1:0] alu_factor;
    logic [CNT_W-1:0] alu_order_cnt;
    logic             alu_vld;
    logic [WID_D-1:0] alu_res;
    logic [CNT_W-1:0] alu_order_cnt_o;
    logic             busy;
    logic             done;
    logic [WID_D-1:0] result;
    logic             err;

    modport slave (
        input  start, x, deg, coef_rdata, alu_res, alu_order_cnt_o,
        output coef_rd, coef_addr, alu_a_left, alu_a_right, alu_factor,
               alu_order_cnt, alu_vld, busy, done, result, err
    );

    modport master (
        output start, x, deg, coef_rdata, alu_res, alu_order_cnt_o,
        input  coef_rd, coef_addr, alu_a_left, alu_a_right, alu_factor,
               alu_order_cnt, alu_vld, busy, done, result, err
    );
endinterface

// File: rtl/polyeval_seq.sv
// Sequential Horner polynomial evaluator driving an external coefficient memory
// and an external modular multiply-add ALU. Define POLYEVAL_SEQ_CHK_EN to enable
// the sticky ALU order-count check on err.
module polyeval_seq #(
    parameter int WID_D = 32,
    parameter int WID_F = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    polyeval_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_EXE  = 3'd2,
        ST_CAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_J = (CNT_W+1)'(1);

    state_t           state_r;
    logic [WID_F-1:0] x_r;
    logic [CNT_W-1:0] deg_r;
    logic [WID_D-1:0] acc_r;
    logic [CNT_W:0]   j_r;
    logic             coef_rd_r;
    logic [CNT_W-1:0] coef_addr_r;
    logic [WID_D-1:0] a_left_r;
    logic [WID_D-1:0] a_right_r;
    logic [WID_F-1:0] factor_r;
    logic [CNT_W-1:0] order_r;
    logic             alu_vld_r;
    logic             busy_r;
    logic             done_r;
    logic [WID_D-1:0] result_r;

    // Main evaluation FSM; all strobes default low and are raised on entry to their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            x_r         <= {WID_F{1'b0}};
            deg_r       <= {CNT_W{1'b0}};
            acc_r       <= {WID_D{1'b0}};
            j_r         <= {(CNT_W+1){1'b0}};
            coef_rd_r   <= 1'b0;
            coef_addr_r <= {CNT_W{1'b0}};
            a_left_r    <= {WID_D{1'b0}};
            a_right_r   <= {WID_D{1'b0}};
            factor_r    <= {WID_F{1'b0}};
            order_r     <= {CNT_W{1'b0}};
            alu_vld_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {WID_D{1'b0}};
        end else begin
            coef_rd_r <= 1'b0;
            alu_vld_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_r         <= bus.x;
                        deg_r       <= bus.deg;
                        acc_r       <= {WID_D{1'b0}};
                        j_r         <= {(CNT_W+1){1'b0}};
                        coef_rd_r   <= 1'b1;
                        coef_addr_r <= bus.deg;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    alu_vld_r <= 1'b1;
                    a_right_r <= acc_r;
                    factor_r  <= x_r;
                    order_r   <= j_r[CNT_W-1:0];
                    state_r   <= ST_EXE;
                end
                ST_EXE: begin
                    a_left_r <= bus.coef_rdata;
                    state_r  <= ST_CAP;
                end
                ST_CAP: begin
                    acc_r <= bus.alu_res;
                    if (j_r == {1'b0, deg_r}) begin
                        // result is published together with the done pulse
                        done_r   <= 1'b1;
                        result_r <= bus.alu_res;
                        state_r  <= ST_DONE;
                    end else begin
                        j_r         <= j_r + ONE_J;
                        coef_rd_r   <= 1'b1;
                        coef_addr_r <= coef_addr_r - ONE_C;
                        state_r     <= ST_RD;
                    end
                end
                ST_DONE: begin
                    result_r <= acc_r;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef POLYEVAL_SEQ_CHK_EN
    logic             err_r;
    logic [CNT_W-1:0] exp_cnt_s;

    assign exp_cnt_s = j_r[CNT_W-1:0] + ONE_C;

    // Sticky order-count mismatch flag, cleared only by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_CAP) && (bus.alu_order_cnt_o != exp_cnt_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    // Read data arrives during EXE, so the left operand is forwarded then and held after.
    assign bus.alu_a_left    = (state_r == ST_EXE) ? bus.coef_rdata : a_left_r;
    assign bus.alu_a_right   = a_right_r;
    assign bus.alu_factor    = factor_r;
    assign bus.alu_order_cnt = order_r;
    assign bus.alu_vld       = alu_vld_r;
    assign bus.coef_rd       = coef_rd_r;
    assign bus.coef_addr     = coef_addr_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.result        = result_r;

endmodule

// File: tb/tb_polyeval_seq.sv
// Self-checking bench for polyeval_seq: table-driven evaluations with a result
// scoreboard, plus hand sequences for ignored start, mid-run reset and order check.
module tb_polyeval_seq;

    localparam int WID_D   = 32;
    localparam int WID_F   = 32;
    localparam int CNT_W   = 5;
    localparam int MOD_NUM = 30;

`ifdef POLYEVAL_SEQ_CHK_EN
    localparam int EXP_BAD_ERR = 1;
`else
    localparam int EXP_BAD_ERR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    polyeval_seq_if #(.WID_D(WID_D), .WID_F(WID_F), .CNT_W(CNT_W)) intf ();

    polyeval_seq #(.WID_D(WID_D), .WID_F(WID_F), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [WID_D-1:0] mem [0:31];
    bit               bad_cnt = 1'b0;
    logic [WID_D-1:0] alu_log [$];

    function automatic logic [WID_D-1:0] alu_model(input logic [WID_D-1:0] a,
                                                   input logic [WID_D-1:0] b,
                                                   input logic [WID_F-1:0] f);
        longint unsigned t;
        t = (64'(a) + 64'(b) * 64'(f)) % 64'(MOD_NUM);
        return WID_D'(t);
    endfunction

    // One-cycle coefficient memory and one-cycle ALU
    always @(posedge clk) begin
        if (intf.coef_rd) intf.coef_rdata <= mem[intf.coef_addr];
        if (intf.alu_vld) begin
            intf.alu_res         <= alu_model(intf.alu_a_left, intf.alu_a_right, intf.alu_factor);
            intf.alu_order_cnt_o <= intf.alu_order_cnt + (bad_cnt ? CNT_W'(2) : CNT_W'(1));
            alu_log.push_back(alu_model(intf.alu_a_left, intf.alu_a_right, intf.alu_factor));
        end
    end

    typedef struct {
        logic [WID_D-1:0] res;
        int               cyc_exp;
        string            name;
    } sb_t;
    sb_t sb_q [$];

    typedef struct {
        int    deg;
        int    x;
        int    c0, c1, c2, fill;
        int    exp_res;
        int    lat;
        string name;
    } vec_t;
    vec_t vecs [5];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input int c0, input int c1, input int c2, input int fill);
        for (int i = 0; i < 32; i++) begin
            mem[i] = (i == 0) ? WID_D'(c0) : (i == 1) ? WID_D'(c1) :
                     (i == 2) ? WID_D'(c2) : WID_D'(fill);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the start edge.
    task automatic do_start(input int deg, input int x, input int exp_res,
                            input int lat, input string name);
        sb_t e;
        intf.deg   = CNT_W'(deg);
        intf.x     = WID_F'(x);
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        e.res     = WID_D'(exp_res);
        e.cyc_exp = cyc + lat;   // cyc now equals the start edge index k
        e.name    = name;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        sb_t e;
        int  n;
        if (sb_q.size() == 0) begin
            chk("scoreboard empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        n = 0;
        while (!intf.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!intf.done) begin
            chk({e.name, " done timeout"}, 0, 1);
            return;
        end
        chk({e.name, " result"}, intf.result, e.res);
        chk({e.name, " done cycle"}, cyc + 1, e.cyc_exp);
        chk({e.name, " busy at done"}, intf.busy, 1);
        @(negedge clk);
        chk({e.name, " done one pulse"}, intf.done, 0);
        chk({e.name, " busy after"}, intf.busy, 0);
        chk({e.name, " result hold"}, intf.result, e.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        intf.start = 1'b0;
        intf.x     = '0;
        intf.deg   = '0;
        load_mem(0, 0, 0, 0);

        vecs[0] = '{deg: 2,  x: 4, c0: 1,  c1: 2, c2: 3, fill: 0, exp_res: 27, lat: 10, name: "v_deg2"};
        vecs[1] = '{deg: 0,  x: 7, c0: 45, c1: 0, c2: 0, fill: 0, exp_res: 15, lat: 4,  name: "v_deg0"};
        vecs[2] = '{deg: 1,  x: 2, c0: 5,  c1: 1, c2: 0, fill: 0, exp_res: 7,  lat: 7,  name: "v_deg1"};
        vecs[3] = '{deg: 3,  x: 3, c0: 1,  c1: 2, c2: 3, fill: 4, exp_res: 22, lat: 13, name: "v_deg3"};
        vecs[4] = '{deg: 31, x: 1, c0: 1,  c1: 1, c2: 1, fill: 1, exp_res: 2,  lat: 97, name: "v_deg31"};

        repeat (3) @(negedge clk);
        chk("reset busy", intf.busy, 0);
        chk("reset done", intf.done, 0);
        chk("reset result", intf.result, 0);
        chk("reset coef_rd", intf.coef_rd, 0);
        chk("reset alu_vld", intf.alu_vld, 0);
        chk("reset err", intf.err, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            load_mem(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].fill);
            do_start(vecs[i].deg, vecs[i].x, vecs[i].exp_res, vecs[i].lat, vecs[i].name);
            chk({vecs[i].name, " coef_addr"}, intf.coef_addr, vecs[i].deg);
            wait_done();
            chk({vecs[i].name, " err"}, intf.err, 0);
        end

        // Operand sequencing, ALU step values and an ignored start during busy
        load_mem(1, 2, 3, 0);
        alu_log.delete();
        do_start(2, 4, 27, 10, "ign");
        chk("ign coef_rd", intf.coef_rd, 1);
        chk("ign alu_vld in RD", intf.alu_vld, 0);
        intf.start = 1'b1;
        intf.deg   = CNT_W'(5);
        intf.x     = WID_F'(9);
        @(negedge clk);
        intf.start = 1'b0;
        chk("ign alu_vld", intf.alu_vld, 1);
        chk("ign coef_rd in EXE", intf.coef_rd, 0);
        chk("ign a_left", intf.alu_a_left, 3);
        chk("ign a_right", intf.alu_a_right, 0);
        chk("ign factor", intf.alu_factor, 4);
        chk("ign order", intf.alu_order_cnt, 0);
        wait_done();
        chk("ign alu steps", alu_log.size(), 3);
        if (alu_log.size() == 3) begin
            chk("ign alu step0", alu_log[0], 3);
            chk("ign alu step1", alu_log[1], 14);
            chk("ign alu step2", alu_log[2], 27);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (intf.done) dones++;
            @(negedge clk);
        end
        chk("ign extra done", dones, 0);
        chk("ign result kept", intf.result, 27);

        // Reset during the EXE cycle of step 1
        do_start(2, 4, 27, 10, "rst");
        n = 0;
        while (!(intf.alu_vld && intf.alu_order_cnt == CNT_W'(1)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst reached step1 EXE", intf.alu_vld, 1);
        rst = 1'b1;
        #1;
        chk("rst busy", intf.busy, 0);
        chk("rst done", intf.done, 0);
        chk("rst result", intf.result, 0);
        chk("rst alu_vld", intf.alu_vld, 0);
        chk("rst a_left", intf.alu_a_left, 0);
        chk("rst a_right", intf.alu_a_right, 0);
        chk("rst factor", intf.alu_factor, 0);
        chk("rst coef_addr", intf.coef_addr, 0);
        chk("rst err", intf.err, 0);
        void'(sb_q.pop_front());
        load_mem(5, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_start(1, 2, 7, 7, "post_rst");
        chk("post_rst busy", intf.busy, 1);
        wait_done();

        // ALU returns a wrong order count
        bad_cnt = 1'b1;
        load_mem(1, 2, 3, 0);
        do_start(2, 4, 27, 10, "badcnt");
        @(negedge clk);
        @(negedge clk);
        chk("badcnt err before CAP", intf.err, 0);
        @(negedge clk);
        chk("badcnt err after CAP", intf.err, EXP_BAD_ERR);
        wait_done();
        chk("badcnt err held", intf.err, EXP_BAD_ERR);
        bad_cnt = 1'b0;
        load_mem(45, 0, 0, 0);
        do_start(0, 7, 15, 4, "clr");
        chk("clr err on start", intf.err, 0);
        wait_done();
        chk("clr err end", intf.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/polyeval_seq.md
POLYEVAL_SEQ -- requirements
Module: polyeval_seq

Interface
REQ-001 SHALL have parameter WID_D, default 32, data/coefficient/accumulator width.
REQ-002 SHALL have parameter WID_F, default 32, evaluation-point (factor) width.
REQ-003 SHALL have parameter CNT_W, default 5, degree/address/order-count width.
REQ-004 SHALL have ports: clk input 1, sole clock; rst input 1, asynchronous active-high reset.
REQ-005 SHALL have ports: start input 1, request evaluation; x input WID_F, evaluation point; deg input CNT_W, polynomial degree.
REQ-006 SHALL have ports: coef_rd output 1, coefficient read strobe; coef_addr output CNT_W, coefficient index; coef_rdata input WID_D, read data valid exactly 1 cycle after coef_rd.
REQ-007 SHALL have ports: alu_a_left output WID_D, alu_a_right output WID_D, alu_factor output WID_F, alu_order_cnt output CNT_W, alu_vld output 1; these are the ALU step operands and valid.
REQ-008 SHALL have ports: alu_res input WID_D, ALU result (a_left + a_right*factor) mod MOD_NUM, registered 1 cycle after alu_vld; alu_order_cnt_o input CNT_W, ALU order count + 1, same timing.
REQ-009 SHALL have ports: busy output 1; done output 1, one-cycle completion pulse; result output WID_D, polynomial value; err output 1, sticky order-count mismatch.

Function
REQ-010 SHALL evaluate p(x) = sum c_i*x^i mod MOD_NUM by Horner: acc=0; for j=0..deg: acc = c_(deg-j) + acc*x via one ALU step.
REQ-011 SHALL implement FSM states IDLE, RD, EXE, CAP, DONE.
REQ-012 IDLE: on start=1 SHALL latch x and deg, clear acc, j and err, and go to RD; start outside IDLE SHALL be ignored.
REQ-013 RD: SHALL assert coef_rd=1 with coef_addr=deg-j for exactly one cycle, then go to EXE.
REQ-014 EXE: SHALL assert alu_vld=1 for one cycle with alu_a_left=coef_rdata, alu_a_right=acc, alu_factor=latched x, alu_order_cnt=j, then go to CAP.
REQ-015 CAP: SHALL load acc<=alu_res; if j==deg go to DONE, else j<=j+1 and go to RD.
REQ-016 DONE: SHALL assert done=1 for one cycle, load result<=acc, then return to IDLE.
REQ-017 With start sampled at edge k, busy SHALL be 1 from cycle k+1 through the DONE cycle, and done SHALL be 1 in cycle k+1+3*(deg+1).
REQ-018 result SHALL hold its value until the next DONE; done and result SHALL be unaffected by an ignored start.
REQ-019 alu_vld and coef_rd SHALL be 0 in every state other than EXE and RD respectively; operand outputs SHALL hold their last values otherwise.
REQ-020 deg=2^CNT_W-1 SHALL be supported; the j counter SHALL be CNT_W+1 bits wide so that it never wraps.
REQ-021 The order-count expected value SHALL be (j+1) truncated to CNT_W bits; wrap to 0 at j=2^CNT_W-1 is legal.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE and all outputs, acc, j, latched x and deg to 0, including mid-operation.
REQ-023 After reset release, the first start SHALL be accepted on the first rising edge with rst=0.

Configuration
REQ-024 Macro POLYEVAL_SEQ_CHK_EN defined: in CAP, alu_order_cnt_o != expected SHALL set err=1, held until the next accepted start or reset; evaluation SHALL still complete.
REQ-025 Macro POLYEVAL_SEQ_CHK_EN undefined: no check logic SHALL be present and err SHALL be constant 0.

Verification (MOD_NUM=30, 1-cycle coefficient memory and ALU models)
REQ-026 c={1,2,3}, deg=2, x=4, start at edge k -> ALU results 3, 14, 27; result=27; done at cycle k+10; err=0.
REQ-027 deg=0, c0=45, x=7 -> one ALU step; result=15; done at cycle k+4.
REQ-028 Second start pulsed during busy of scenario REQ-026 -> ignored; single done; result=27.
REQ-029 rst pulsed during EXE of step 1 -> all outputs 0 immediately; subsequent start with deg=1, c={5,1}, x=2 -> result=7.
REQ-030 ALU model returns alu_order_cnt_o=j+2 with POLYEVAL_SEQ_CHK_EN defined -> err=1 after first CAP and held; without the macro -> err=0.
REQ-031 deg=31, all c_i=1, x=1 -> 32 steps; result=2; no j wrap; done at cycle k+97.
